hr_local_inject: RTL and testbench
==================================

Name: hr_local_inject

Overview:
- Local injection queue that sits directly upstream of a ring node's local input port (port0_local_i / port1_local_i).
- Buffers 144-bit flits from the attached core/cache and holds the head flit on the node's local input until the node acks it.
- Pops the head on portl*_ack; flags starvation when the ring denies injection for too long.
- One instance per local port.

Parameters:
- DEPTH, 4, number of flit slots (power of two, >=2)
- STARVE_LIM, 16, consecutive un-acked cycles with a valid head before starve_o asserts (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- enq_flit_i  input  144  flit from core; 144'h0 means "no flit"
- enq_valid_i  input  1  enqueue request
- enq_ready_o  output  1  queue can accept this cycle
- port_local_o  output  144  head flit to node local input; 144'h0 when empty
- ack_i  input  1  node accepted the presented flit (node portl*_ack)
- count_o  output  $clog2(DEPTH)+1  occupancy
- starve_o  output  1  head blocked for STARVE_LIM cycles

Behaviour:
- Single clock domain. rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset clears pointers, count, and the starvation counter. After the reset edge: port_local_o=0, count_o=0, enq_ready_o=1, starve_o=0. rst dominates enq and ack in the same cycle. A mid-operation reset discards all queued flits.
- enq_ready_o = (count < DEPTH). It is combinational from registered count and has no bypass of a same-cycle dequeue.
- Enqueue fires when enq_valid_i & enq_ready_o & (enq_flit_i != 0). A zero flit is silently dropped and count is unchanged.
- enq_valid_i while full is ignored: the flit is lost and the core must honour enq_ready_o.
- port_local_o is the head slot read combinationally from registered storage. It is 144'h0 when count==0.
- Fall-through latency: a flit enqueued at edge N is presented from edge N onward (visible in cycle N+1).
- Dequeue fires when ack_i & (count != 0), sampled at the edge. The next flit is presented in the following cycle. ack_i while empty is ignored.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any count 1..DEPTH-1.
- At count==DEPTH, a same-cycle enqueue is refused even if ack_i is high.
- Pointers wrap modulo DEPTH.
- Starvation counter: cleared on a dequeue or when empty. Otherwise, when count!=0 and !ack_i, it increments, saturating at STARVE_LIM.
- starve_o = (starve_cnt == STARVE_LIM), registered. It drops the cycle after the acking edge.
- No FSM beyond the occupancy states EMPTY (count==0), PARTIAL, and FULL (count==DEPTH), with transitions as above.

Decomposition:
- Shared package hr_pkg:
  - FLIT_W=144 (matching `control_w`)
  - FLIT_NONE=144'h0
  - helper function flit_is_valid(f) = (f != FLIT_NONE)
- One sub-module, hr_flit_fifo: generic DEPTH x FLIT_W storage with wr_en, rd_en, head, and count.
- hr_local_inject adds the zero-flit filtering, ack mapping, and starvation counter.

Test Plan:
1. Reset, then enqueue 144'h0123456789abcdef0123456789abcdef1855 with ack_i=0.
   -> Next cycle: port_local_o equals that flit, count_o=1, enq_ready_o=1.
2. Enqueue 4 distinct flits (DEPTH=4) with no ack.
   -> count_o=4, enq_ready_o=0.
   -> A 5th enq_valid_i is ignored; count stays 4 and head is unchanged.
3. From full, pulse ack_i for 4 consecutive cycles.
   -> Flits emerge in FIFO order, one per cycle.
   -> port_local_o=0 and count_o=0 after the 4th edge.
   -> A further ack_i has no effect.
4. At count=2, assert enq_valid_i and ack_i in the same cycle.
   -> count stays 2, head advances to the 2nd flit, and the new flit lands at the tail.
   -> Repeat across wrap-around (>DEPTH ops): order is preserved.
5. Enqueue 144'h0 with enq_valid_i=1.
   -> count_o stays 0, port_local_o stays 0.
6. Hold one flit un-acked for 16 cycles.
   -> starve_o rises after the 16th edge and stays high.
   -> ack_i clears it the next cycle.
   -> Asserting rst mid-starvation with 3 flits queued gives count_o=0, port_local_o=0, starve_o=0 after one edge.

Source files
------------

// File: rtl/hr_pkg.sv
// Shared flit types and helpers for the ring local-injection path.
// No logic and no latency; the valid-flit test is combinational.
package hr_pkg;

    localparam int FLIT_W = 144;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t FLIT_NONE = '0;

    // Occupancy classes of an injection queue.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    // An all-zero flit means "no flit" on every local-port bus.
    function automatic logic flit_is_valid(input flit_t f);
        return f != FLIT_NONE;
    endfunction

endpackage

// File: rtl/hr_flit_fifo.sv
// DEPTH x FLIT_W circular flit store: head is read combinationally, so a write is visible the cycle after its edge.
// No internal backpressure; the caller qualifies wr_en against full and rd_en against empty.
module hr_flit_fifo
    import hr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  flit_t                  wr_dat,
    input  logic                   rd_en,
    output flit_t                  head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    flit_t             mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;

    // Storage carries no reset; an empty queue never exposes its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = occ;

endmodule

// File: rtl/hr_local_inject.sv
// Injection queue ahead of a ring node local port; a flit enqueued at edge N is presented from edge N, popped on ack_i.
// enq_ready_o drops at DEPTH with no same-cycle dequeue bypass; starve_o flags STARVE_LIM un-acked head cycles.
module hr_local_inject
    import hr_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_W-1:0]      enq_flit_i,
    input  logic                   enq_valid_i,
    output logic                   enq_ready_o,
    output logic [FLIT_W-1:0]      port_local_o,
    input  logic                   ack_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   starve_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIM_C   = SW'(STARVE_LIM);

    flit_t         head;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    occ_t          occ;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == DEPTH_C) begin
            occ = OCC_FULL;
        end
    end

    // Zero flits are dropped here so they never consume a slot.
    assign enq_ready_o = (occ != OCC_FULL);
    assign wr_en       = enq_valid_i & enq_ready_o & flit_is_valid(enq_flit_i);
    assign rd_en       = ack_i & (occ != OCC_EMPTY);

    hr_flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_dat (enq_flit_i),
        .rd_en  (rd_en),
        .head   (head),
        .count  (count)
    );

    // Counts consecutive cycles a presented head went un-acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (rd_en || (occ == OCC_EMPTY)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIM_C) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_o     = (starve_cnt == LIM_C);
    assign port_local_o = (occ == OCC_EMPTY) ? FLIT_NONE : head;
    assign count_o      = count;

endmodule

// File: tb/tb_hr_local_inject.sv
// Bench for hr_local_inject: a vector table plus hand sequences, with a flit scoreboard checked every cycle.
module tb_hr_local_inject;

    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 16;
    localparam int CW         = $clog2(DEPTH) + 1;

    localparam logic [143:0] FA = 144'h0123456789abcdef0123456789abcdef1855;
    localparam logic [143:0] FB = 144'h1111_2222_3333_4444_5555_6666_7777_8888_0b0b;
    localparam logic [143:0] FC = 144'hc0c0_0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [143:0] FD = 144'hdddd_dddd_dddd_dddd_dddd_dddd_dddd_dddd_dddd;
    localparam logic [143:0] FE = 144'heeee_0000_0000_0000_0000_0000_0000_0000_eeee;

    logic          clk = 1'b0;
    logic          rst;
    logic [143:0]  enq_flit_i;
    logic          enq_valid_i;
    logic          enq_ready_o;
    logic [143:0]  port_local_o;
    logic          ack_i;
    logic [CW-1:0] count_o;
    logic          starve_o;

    int total = 0;
    int bad   = 0;

    logic [143:0] sb_q [$];
    int           m_starve = 0;

    always #5 clk = ~clk;

    hr_local_inject #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enq_flit_i   (enq_flit_i),
        .enq_valid_i  (enq_valid_i),
        .enq_ready_o  (enq_ready_o),
        .port_local_o (port_local_o),
        .ack_i        (ack_i),
        .count_o      (count_o),
        .starve_o     (starve_o)
    );

    typedef struct {
        logic          rst;
        logic          vld;
        logic [143:0]  flit;
        logic          ack;
        logic [CW-1:0] cnt;
        logic          rdy;
        logic [143:0]  head;
        logic          st;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic r, input logic v, input logic [143:0] f,
                                input logic a, input int c, input logic rd,
                                input logic [143:0] h, input logic s);
        vec_t x;
        x.rst  = r;
        x.vld  = v;
        x.flit = f;
        x.ack  = a;
        x.cnt  = CW'(c);
        x.rdy  = rd;
        x.head = h;
        x.st   = s;
        return x;
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare against it.
    task automatic step(input logic r, input logic v, input logic [143:0] f, input logic a);
        logic [143:0] pre_head;
        logic [143:0] popped;
        logic         deq;
        logic         enq;
        int           pre_size;
        rst         = r;
        enq_valid_i = v;
        enq_flit_i  = f;
        ack_i       = a;
        pre_head    = port_local_o;
        pre_size    = sb_q.size();
        @(posedge clk);
        if (r) begin
            sb_q.delete();
            m_starve = 0;
        end else begin
            deq = a && (pre_size != 0);
            enq = v && (pre_size < DEPTH) && (f != 144'h0);
            if (deq || pre_size == 0) begin
                m_starve = 0;
            end else if (m_starve < STARVE_LIM) begin
                m_starve++;
            end
            if (deq) begin
                popped = sb_q.pop_front();
                chk("sb_pop", pre_head, popped);
            end
            if (enq) begin
                sb_q.push_back(f);
            end
        end
        #1;
        chk("sb_head", port_local_o, (sb_q.size() != 0) ? sb_q[0] : 144'h0);
        chk("sb_count", 144'(count_o), 144'(sb_q.size()));
        chk("sb_ready", 144'(enq_ready_o), 144'(sb_q.size() < DEPTH));
        chk("sb_starve", 144'(starve_o), 144'(m_starve == STARVE_LIM));
    endtask

    function automatic logic [143:0] rnd_flit();
        logic [143:0] f;
        f = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        f[0] = 1'b1;
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [143:0] nf;
        rst         = 1'b1;
        enq_valid_i = 1'b0;
        enq_flit_i  = '0;
        ack_i       = 1'b0;

        //           rst   vld   flit     ack   cnt rdy   head     starve
        tbl[0]  = mk(1'b1, 1'b1, FE,      1'b1, 0, 1'b1, 144'h0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, FA,      1'b0, 1, 1'b1, FA,     1'b0);
        tbl[2]  = mk(1'b0, 1'b1, FB,      1'b0, 2, 1'b1, FA,     1'b0);
        tbl[3]  = mk(1'b0, 1'b1, FC,      1'b0, 3, 1'b1, FA,     1'b0);
        tbl[4]  = mk(1'b0, 1'b1, FD,      1'b0, 4, 1'b0, FA,     1'b0);
        tbl[5]  = mk(1'b0, 1'b1, FE,      1'b0, 4, 1'b0, FA,     1'b0);
        tbl[6]  = mk(1'b0, 1'b1, FE,      1'b1, 3, 1'b1, FB,     1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 144'h0,  1'b1, 2, 1'b1, FC,     1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 144'h0,  1'b1, 1, 1'b1, FD,     1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 144'h0,  1'b1, 0, 1'b1, 144'h0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 144'h0,  1'b1, 0, 1'b1, 144'h0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 144'h0,  1'b0, 0, 1'b1, 144'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].flit, tbl[i].ack);
            chk($sformatf("tbl%0d_count", i), 144'(count_o), 144'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ready", i), 144'(enq_ready_o), 144'(tbl[i].rdy));
            chk($sformatf("tbl%0d_head", i), port_local_o, tbl[i].head);
            chk($sformatf("tbl%0d_starve", i), 144'(starve_o), 144'(tbl[i].st));
        end

        // Steady enqueue+dequeue at count 2 across several pointer wraps.
        step(1'b0, 1'b1, FA, 1'b0);
        step(1'b0, 1'b1, FB, 1'b0);
        chk("simul_pre_count", 144'(count_o), 144'd2);
        step(1'b0, 1'b1, FC, 1'b1);
        chk("simul_count", 144'(count_o), 144'd2);
        chk("simul_head", port_local_o, FB);
        for (int i = 0; i < 10; i++) begin
            nf = rnd_flit();
            step(1'b0, 1'b1, nf, 1'b1);
            chk($sformatf("wrap%0d_count", i), 144'(count_o), 144'd2);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 144'h0, 1'b1);
        end
        chk("drain_count", 144'(count_o), 144'd0);

        // Starvation: one flit held un-acked.
        step(1'b1, 1'b0, 144'h0, 1'b0);
        step(1'b0, 1'b1, FD, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 144'h0, 1'b0);
            chk($sformatf("starve_k%0d", k), 144'(starve_o), 144'(k >= STARVE_LIM));
        end
        step(1'b0, 1'b0, 144'h0, 1'b1);
        chk("starve_ack_clear", 144'(starve_o), 144'd0);
        chk("starve_ack_count", 144'(count_o), 144'd0);

        // Reset while starving with three flits queued.
        step(1'b0, 1'b1, FA, 1'b0);
        step(1'b0, 1'b1, FB, 1'b0);
        step(1'b0, 1'b1, FC, 1'b0);
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b0, 144'h0, 1'b0);
        end
        chk("mid_starve_high", 144'(starve_o), 144'd1);
        chk("mid_count3", 144'(count_o), 144'd3);
        step(1'b1, 1'b1, FE, 1'b1);
        chk("rst_count", 144'(count_o), 144'd0);
        chk("rst_head", port_local_o, 144'h0);
        chk("rst_starve", 144'(starve_o), 144'd0);
        chk("rst_ready", 144'(enq_ready_o), 144'd1);
        step(1'b0, 1'b0, 144'h0, 1'b1);
        chk("post_rst_head", port_local_o, 144'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
